// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester round-robin arbiter sharing one 2:1 mux and a registered output channel
module mux #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux_share_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, last_q, last_d, valid_q, valid_d, space;
  logic [WIDTH-1:0] data_q, data_d, mux_y;
  logic [CW-1:0] cnt_q, cnt_d;
  mux #(.WIDTH(WIDTH)) u_mux (.a(data_a), .b(data_b), .s(sel_q), .y(mux_y));
  // last_q: 0 = A served last, 1 = B served last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (req_a && req_b) state_d = last_q ? GNT_A : GNT_B;
        else if (req_a) state_d = GNT_A;
        else if (req_b) state_d = GNT_B;
      GNT_A:
        if (!req_a) begin
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = req_b ? GNT_B : IDLE;
        end else if (ack_a) begin
          cnt_d = (cnt_q == LIM) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LIM && req_b) begin
            last_d  = 1'b0;
            state_d = GNT_B;
          end
        end
      GNT_B:
        if (!req_b) begin
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = req_a ? GNT_A : IDLE;
        end else if (ack_b) begin
          cnt_d = (cnt_q == LIM) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LIM && req_a) begin
            last_d  = 1'b1;
            state_d = GNT_A;
          end
        end
      default: state_d = IDLE;
    endcase
    sel_d = (state_d == GNT_B) ? 1'b1 : (state_d == GNT_A) ? 1'b0 : sel_q;
  end
  always_comb begin
    space   = !valid_q || out_ready;
    ack_a   = (state_q == GNT_A) && req_a && space;
    ack_b   = (state_q == GNT_B) && req_b && space;
    data_d  = (ack_a || ack_b) ? mux_y : data_q;
    valid_d = ack_a || ack_b || (valid_q && !out_ready);
    busy    = state_q != IDLE;
  end
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed checks of arbitration, backpressure, handoff and reset for mux_share_arbiter
module tb_mux_share_arbiter;
  logic clk = 1'b0, rst_n, req_a, req_b, ack_a, ack_b, sel, out_valid, out_ready, busy;
  logic [3:0] data_a, data_b, out_data;
  int n = 0, errs = 0;
  mux_share_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 4'h0; data_b = 4'h0; out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    req_a = 1'b1; data_a = 4'h9; out_ready = 1'b1;
    #1 chk("idle_no_ack", ack_a, 0);
    tick;
    chk("gnt_a_busy", busy, 1);
    chk("gnt_a_sel", sel, 0);
    chk("gnt_a_ack", ack_a, 1);
    chk("gnt_a_valid0", out_valid, 0);
    tick;
    chk("beat1_valid", out_valid, 1);
    chk("beat1_data", out_data, 4'h9);
    chk("beat1_ack", ack_a, 1);
    data_a = 4'h5;
    tick;
    chk("beat2_data", out_data, 4'h5);
    out_ready = 1'b0;
    #1 chk("bp_ack", ack_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_data", out_data, 4'h5);
      chk("bp_valid", out_valid, 1);
      chk("bp_ack_hold", ack_a, 0);
      chk("bp_cnt", dut.cnt_q, 2);
    end
    out_ready = 1'b1; data_a = 4'h6;
    #1 chk("bp_resume_ack", ack_a, 1);
    tick;
    chk("beat3_data", out_data, 4'h6);
    chk("beat3_cnt", dut.cnt_q, 3);
    data_a = 4'h7;
    tick;
    chk("nocont_data", out_data, 4'h7);
    chk("nocont_cnt", dut.cnt_q, 0);
    chk("nocont_sel", sel, 0);
    chk("nocont_busy", busy, 1);
    req_a = 1'b0;
    tick;
    chk("drop_busy", busy, 0);
    chk("drop_valid", out_valid, 0);
    chk("drop_data", out_data, 4'h7);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hC;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk("tie_valid", out_valid, (i >= 2) ? 8'd1 : 8'd0);
      chk("tie_data", out_data, (i < 2) ? 8'h0 : (i >= 6 && i <= 9) ? 8'hC : 8'h3);
      chk("tie_sel", sel, (i >= 5 && i <= 8) ? 8'd1 : 8'd0);
    end
    tick;
    chk("ho_data", out_data, 4'h3);
    req_a = 1'b0;
    #1 chk("ho_no_ack", ack_a, 0);
    tick;
    chk("ho_sel", sel, 1);
    chk("ho_busy", busy, 1);
    chk("ho_valid", out_valid, 0);
    chk("ho_ack_b", ack_b, 1);
    tick;
    chk("ho_b_data", out_data, 4'hC);
    chk("ho_b_valid", out_valid, 1);
    req_b = 1'b0;
    tick;
    chk("ho_idle", busy, 0);
    chk("ho_drain", out_valid, 0);
    req_a = 1'b1; req_b = 1'b1;
    tick;
    chk("ho_tie_sel", sel, 0);
    chk("ho_tie_busy", busy, 1);
    req_a = 1'b0;
    tick;
    chk("mr_gnt_b", sel, 1);
    tick;
    chk("mr_valid", out_valid, 1);
    chk("mr_data", out_data, 4'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", out_valid, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_sel", sel, 0);
    chk("mr_rst_ack_b", ack_b, 0);
    tick;
    req_a = 1'b1; req_b = 1'b1;
    rst_n = 1'b1;
    tick;
    chk("mr_first_sel", sel, 0);
    chk("mr_first_busy", busy, 1);
    chk("mr_first_ack", ack_a, 1);
    tick;
    chk("mr_first_data", out_data, 4'h3);
    chk("mr_first_valid", out_valid, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Two-requester round-robin arbiter that time-shares one parameterized 2:1 mux datapath (`mux #(WIDTH)`) and one registered output channel.
- Each requester holds its grant while it keeps its request up, bounded by a fairness limit.
- The block drives the mux select, registers the selected word, and applies valid/ready backpressure toward the consumer.
- Sits between two producer blocks and a single downstream sink.

Parameters:
- WIDTH, 1, data width of each requester and of the output (matches the mux width parameter).
- MAX_HOLD, 4, maximum consecutive accepted beats for one requester while the other is waiting (≥1).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A has data; held high for the duration of its burst.
- data_a  input  WIDTH  requester A data; mux `a` input.
- req_b  input  1  requester B has data.
- data_b  input  WIDTH  requester B data; mux `b` input.
- ack_a  output  1  combinational; beat from A accepted this cycle.
- ack_b  output  1  combinational; beat from B accepted this cycle.
- sel  output  1  registered mux select: 0=A, 1=B.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered; out_data is valid.
- out_ready  input  1  sink accepts out_data this cycle.
- busy  output  1  state ≠ IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, out_data=0, out_valid=0, beat_cnt=0.
  - Priority pointer last_served=B, so A wins the first tie.
  - ack_a=ack_b=0 and busy=0 while in reset.
- FSM states: IDLE, GNT_A, GNT_B. Transitions are registered; sel is updated on entry: 0 for GNT_A, 1 for GNT_B. sel holds its value in IDLE.
- IDLE:
  - req_a&req_b → grant the requester other than last_served.
  - Only req_a → GNT_A. Only req_b → GNT_B. Neither → stay.
  - No ack is issued in IDLE, so there is 1 cycle of grant latency.
- Accept rule: space = !out_valid | out_ready.
  - ack_a = (state==GNT_A) & req_a & space.
  - ack_b = (state==GNT_B) & req_b & space.
- On ack:
  - out_data <= mux output (data of the granted requester).
  - out_valid <= 1.
  - beat_cnt <= beat_cnt+1.
  - out_valid is seen 1 cycle after the ack.
- Output hold:
  - out_valid & !out_ready → out_data and out_valid are held and no ack is issued.
  - out_valid & out_ready & no ack that cycle → out_valid <= 0.
  - Simultaneous drain and ack is allowed (full throughput, one beat/cycle).
- In GNT_X (Y = the other requester):
  - req_X low → last_served<=X, beat_cnt<=0; next = GNT_Y if req_Y else IDLE. No idle bubble when Y waits.
  - ack_X with beat_cnt==MAX_HOLD-1 and req_Y high → forced switch: last_served<=X, beat_cnt<=0, next=GNT_Y.
  - Same condition with req_Y low → stay in GNT_X, beat_cnt<=0; the limit applies only under contention.
  - Otherwise stay. Stall cycles (no ack) do not advance beat_cnt.
- Switch timing: a requester dropping req mid-stall loses the grant. A beat already registered in out_data is still delivered; it is never dropped or duplicated.
- beat_cnt width: $clog2(MAX_HOLD)+1. It never exceeds MAX_HOLD-1.
- Reset mid-burst: the pending output beat is discarded (out_valid=0) and the arbiter restarts in IDLE with A-priority.
- Requester data must be stable while its req is high and its ack is low. The arbiter does not check this.

Test Plan:
- Reset/idle (WIDTH=4): assert rst_n=0 mid-cycle → out_valid=0, sel=0, out_data=4'h0, busy=0 immediately, without waiting for a clock edge; releasing with no req keeps IDLE.
- Single requester: req_a=1, data_a=4'h9, out_ready=1 → IDLE→GNT_A in cycle 1, ack_a in cycle 2, out_valid=1 with out_data=4'h9 in cycle 3; one beat per cycle thereafter.
- Tie after reset: req_a=req_b=1, data_a=4'h3, data_b=4'hC, ready high → 4 beats of 4'h3 (sel=0), then sel=1 and 4 beats of 4'hC, alternating every MAX_HOLD=4 beats.
- Backpressure: during GNT_A with out_data=4'h5 valid, hold out_ready=0 for 3 cycles → ack_a=0, out_data stays 4'h5, beat_cnt frozen; out_ready=1 resumes with the next beat the same cycle.
- Handoff: A bursts 2 beats then drops req_a while req_b is high → GNT_B the next cycle with no IDLE; the next tie after B finishes grants A.
- Reset mid-burst: rst_n pulse low while out_valid=1 in GNT_B → out_valid=0 and state IDLE; after release with both reqs high, A is granted first.
